// File: rtl/compression_lane_arbiter.sv
// Round-robin arbiter merging per-lane compressed block streams onto one registered output.
// A lane keeps the grant from its first beat until it delivers a beat with last set.
module compression_lane_arbiter #(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 512,
   parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [NUM_LANES-1:0]        i_in_valid,
   input  logic [NUM_LANES*DATA_W-1:0] i_in_data,
   input  logic [NUM_LANES-1:0]        i_in_last,
   output logic [NUM_LANES-1:0]        o_in_ready,
   output logic                        o_out_valid,
   output logic [DATA_W-1:0]           o_out_data,
   output logic                        o_out_last,
   output logic [LANE_W-1:0]           o_out_lane,
   input  logic                        i_out_ready
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   localparam logic [LANE_W:0] NL = (LANE_W+1)'(NUM_LANES);

   state_t                r_state, w_state_nxt;
   logic [LANE_W-1:0]     r_ptr, r_gnt;
   logic [LANE_W-1:0]     w_ptr_nxt, w_gnt_nxt, w_pick, w_off, w_gnt_inc;
   logic [LANE_W:0]       w_sum;
   logic [NUM_LANES-1:0]  w_rot;
   logic                  w_any, w_load_ok, w_xfer, w_gnt_valid, w_gnt_last;
   logic [DATA_W-1:0]     w_gnt_data;

   assign w_load_ok = !o_out_valid || i_out_ready;

   // Rotate so bit k is lane (ptr+k) mod N; the lowest set bit is the next winner.
   assign w_rot = NUM_LANES'({i_in_valid, i_in_valid} >> r_ptr);

   always_comb begin
      w_any = 1'b0;
      w_off = '0;
      for (int k = NUM_LANES-1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_any = 1'b1;
            w_off = LANE_W'(k);
         end
      end
      w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
      w_pick = (w_sum >= NL) ? LANE_W'(w_sum - NL) : w_sum[LANE_W-1:0];
   end

   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_last  = 1'b0;
      w_gnt_data  = '0;
      o_in_ready  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (r_gnt == LANE_W'(i)) begin
            w_gnt_valid   = i_in_valid[i];
            w_gnt_last    = i_in_last[i];
            w_gnt_data    = i_in_data[i*DATA_W +: DATA_W];
            o_in_ready[i] = (r_state == S_LOCKED) && w_load_ok;
         end
      end
   end

   assign w_xfer    = (r_state == S_LOCKED) && w_gnt_valid && w_load_ok;
   assign w_gnt_inc = (r_gnt == LANE_W'(NUM_LANES-1)) ? '0 : r_gnt + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (w_xfer && w_gnt_last) begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = w_gnt_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_out_last  <= 1'b0;
         o_out_lane  <= '0;
      end else if (w_xfer) begin
         o_out_valid <= 1'b1;
         o_out_data  <= w_gnt_data;
         o_out_last  <= w_gnt_last;
         o_out_lane  <= r_gnt;
      end else if (i_out_ready) begin
         o_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_compression_lane_arbiter.sv
// Directed bench for compression_lane_arbiter: a 4-lane instance and a 1-lane instance.
module tb_compression_lane_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid, in_last, in_ready;
   logic [63:0] in_data;
   logic        out_ready, out_valid, out_last;
   logic [15:0] out_data;
   logic [1:0]  out_lane;

   logic [0:0]  b_valid, b_last, b_ready;
   logic [15:0] b_data, b_out_data;
   logic        b_out_ready, b_out_valid, b_out_last;
   logic [0:0]  b_out_lane;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   compression_lane_arbiter #(.NUM_LANES(4), .DATA_W(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .i_in_data(in_data),
      .i_in_last(in_last), .o_in_ready(in_ready), .o_out_valid(out_valid),
      .o_out_data(out_data), .o_out_last(out_last), .o_out_lane(out_lane),
      .i_out_ready(out_ready));

   compression_lane_arbiter #(.NUM_LANES(1), .DATA_W(16)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_in_valid(b_valid), .i_in_data(b_data),
      .i_in_last(b_last), .o_in_ready(b_ready), .o_out_valid(b_out_valid),
      .o_out_data(b_out_data), .o_out_last(b_out_last), .o_out_lane(b_out_lane),
      .i_out_ready(b_out_ready));

   // Downstream log of every beat taken by the consumer
   logic [15:0] mon_d[128];
   logic [1:0]  mon_l[128];
   logic        mon_last[128];
   int          mon_c[128];
   int          mon_n = 0;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && mon_n < 128) begin
         mon_d[mon_n]    <= out_data;
         mon_l[mon_n]    <= out_lane;
         mon_last[mon_n] <= out_last;
         mon_c[mon_n]    <= cyc;
         mon_n           <= mon_n + 1;
      end
   end

   // Upstream lane model: lane l sends nblk blocks of bpb beats, data = {lane, block, beat}
   int nblk[4], bpb[4], bi[4], blk[4];
   bit hold[4];

   task automatic drive();
      for (int l = 0; l < 4; l++) begin
         in_valid[l]          = !hold[l] && (blk[l] < nblk[l]);
         in_data[l*16 +: 16]  = {4'(l), 4'(blk[l]), 8'(bi[l])};
         in_last[l]           = (bi[l] == bpb[l] - 1);
      end
   endtask

   task automatic clear_lanes();
      for (int l = 0; l < 4; l++) begin
         nblk[l] = 0; bpb[l] = 1; bi[l] = 0; blk[l] = 0; hold[l] = 0;
      end
      drive();
   endtask

   task automatic step();
      logic [3:0] acc;
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int l = 0; l < 4; l++) begin
         if (acc[l]) begin
            bi[l]++;
            if (bi[l] == bpb[l]) begin
               bi[l] = 0;
               blk[l]++;
            end
         end
      end
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      clear_lanes();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      b_valid = 1'b0; b_last = 1'b0; b_data = '0; b_out_ready = 1'b1;
      clear_lanes();
      nblk[0] = 1; bpb[0] = 2;
      drive();
      step();
      step();
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      checks++;
      if ({out_valid, out_data, out_last, out_lane} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b d=%h l=%b lane=%0d exp all 0", out_valid, out_data, out_last, out_lane);
      end
      checks++;
      if (dut.r_ptr !== 2'd0 || dut.r_gnt !== 2'd0) begin
         failures++; $display("FAIL reset_ptr_gnt got ptr=%0d gnt=%0d exp 0 0", dut.r_ptr, dut.r_gnt);
      end
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 4'b0001) begin failures++; $display("FAIL grant_after_reset got=%b exp=0001", in_ready); end
      do_reset();
   endtask

   task automatic test_single();
      int c0, m0;
      nblk[2] = 1; bpb[2] = 3;
      drive();
      c0 = cyc; m0 = mon_n;
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL single_idle_ready got=%b exp=0000", in_ready); end
      step();
      checks++;
      if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_grant_ready got=%b exp=0100", in_ready); end
      repeat (8) step();
      checks++;
      if (mon_n - m0 != 3) begin
         failures++; $display("FAIL single_count got=%0d exp=3", mon_n - m0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_d[m0+i] !== {4'd2, 4'd0, 8'(i)} || mon_l[m0+i] !== 2'd2 ||
                mon_last[m0+i] !== (i == 2) || mon_c[m0+i] != c0 + 2 + i) begin
               failures++;
               $display("FAIL single_beat%0d got d=%h lane=%0d last=%b cyc=%0d exp d=%h lane=2 last=%b cyc=%0d",
                        i, mon_d[m0+i], mon_l[m0+i], mon_last[m0+i], mon_c[m0+i] - c0,
                        {4'd2, 4'd0, 8'(i)}, (i == 2), 2 + i);
            end
         end
      end
      checks++;
      if (dut.r_ptr !== 2'd3 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         failures++; $display("FAIL single_idle_after got ptr=%0d v=%b rdy=%b exp ptr=3 v=0 rdy=0000", dut.r_ptr, out_valid, in_ready);
      end
   endtask

   task automatic test_fairness();
      int c0, m0, k, b;
      logic [15:0] ed;
      do_reset();
      for (int l = 0; l < 4; l++) begin nblk[l] = 2; bpb[l] = 2; end
      drive();
      c0 = cyc; m0 = mon_n;
      repeat (30) step();
      checks++;
      if (mon_n - m0 != 16) begin
         failures++; $display("FAIL fair_count got=%0d exp=16", mon_n - m0);
      end else begin
         for (int j = 0; j < 16; j++) begin
            k = j / 2; b = j % 2;
            ed = {4'(k % 4), 4'(k / 4), 8'(b)};
            checks++;
            if (mon_d[m0+j] !== ed || mon_l[m0+j] !== 2'(k % 4) || mon_last[m0+j] !== (b == 1) ||
                mon_c[m0+j] != c0 + 2 + 3*k + b) begin
               failures++;
               $display("FAIL fair_beat%0d got d=%h lane=%0d last=%b cyc=%0d exp d=%h lane=%0d last=%b cyc=%0d",
                        j, mon_d[m0+j], mon_l[m0+j], mon_last[m0+j], mon_c[m0+j] - c0, ed, k % 4, b, 2 + 3*k + b);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int m0;
      int pat[12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1};
      logic        pv, pr, pl;
      logic [15:0] pd;
      logic [1:0]  pn;
      do_reset();
      nblk[0] = 1; bpb[0] = 4;
      drive();
      m0 = mon_n;
      for (int i = 0; i < 20; i++) begin
         out_ready = (i < 12) ? pat[i][0] : 1'b1;
         #1;
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_drop cyc%0d got=%b exp=0000", i, in_ready); end
         end
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pn = out_lane;
         step();
         if (pv && !pr) begin
            checks++;
            if ({out_valid, out_data, out_last, out_lane} !== {1'b1, pd, pl, pn}) begin
               failures++;
               $display("FAIL bp_hold cyc%0d got v=%b d=%h l=%b lane=%0d exp v=1 d=%h l=%b lane=%0d",
                        i, out_valid, out_data, out_last, out_lane, pd, pl, pn);
            end
         end
      end
      out_ready = 1'b1;
      checks++;
      if (mon_n - m0 != 4) begin
         failures++; $display("FAIL bp_count got=%0d exp=4", mon_n - m0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_d[m0+i] !== {8'h00, 8'(i)} || mon_l[m0+i] !== 2'd0 || mon_last[m0+i] !== (i == 3)) begin
               failures++;
               $display("FAIL bp_beat%0d got d=%h lane=%0d last=%b exp d=%h lane=0 last=%b",
                        i, mon_d[m0+i], mon_l[m0+i], mon_last[m0+i], {8'h00, 8'(i)}, (i == 3));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int m0;
      do_reset();
      nblk[2] = 1; bpb[2] = 1;
      drive();
      repeat (5) step();
      checks++;
      if (dut.r_ptr !== 2'd3) begin failures++; $display("FAIL wrap_setup_ptr got=%0d exp=3", dut.r_ptr); end
      clear_lanes();
      nblk[1] = 1; bpb[1] = 2;
      drive();
      m0 = mon_n;
      repeat (8) step();
      checks++;
      if (mon_n - m0 != 2 || mon_l[m0] !== 2'd1 || mon_l[m0+1] !== 2'd1 || mon_last[m0+1] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_lane1 got n=%0d lanes=%0d,%0d last=%b exp n=2 lanes=1,1 last=1",
                  mon_n - m0, mon_l[m0], mon_l[m0+1], mon_last[m0+1]);
      end
      checks++;
      if (dut.r_ptr !== 2'd2) begin failures++; $display("FAIL wrap_ptr got=%0d exp=2", dut.r_ptr); end
   endtask

   task automatic test_stall_reset();
      int m0, n;
      do_reset();
      nblk[0] = 1; bpb[0] = 4;
      nblk[1] = 1; bpb[1] = 2;
      drive();
      m0 = mon_n;
      n = 0;
      while (bi[0] != 1 && n < 20) begin step(); n++; end
      checks++;
      if (bi[0] != 1) begin failures++; $display("FAIL stall_first_beat got=%0d exp=1 (timeout)", bi[0]); end
      hold[0] = 1;
      drive();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL stall_lane1_ready cyc%0d got=%b exp=0", i, in_ready[1]); end
         step();
      end
      hold[0] = 0;
      drive();
      n = 0;
      while (bi[0] != 3 && n < 20) begin step(); n++; end
      checks++;
      if (bi[0] != 3) begin failures++; $display("FAIL stall_resume got=%0d exp=3 (timeout)", bi[0]); end
      checks++;
      if (mon_n - m0 < 2 || mon_d[m0+1] !== 16'h0001 || mon_l[m0+1] !== 2'd0) begin
         failures++; $display("FAIL stall_resume_beat got n=%0d d=%h exp n>=2 d=0001", mon_n - m0, mon_d[m0+1]);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({out_valid, out_data, out_last, out_lane} !== 20'h0 || in_ready !== 4'b0000) begin
         failures++;
         $display("FAIL midreset_outputs got v=%b d=%h l=%b lane=%0d rdy=%b exp all 0",
                  out_valid, out_data, out_last, out_lane, in_ready);
      end
      checks++;
      if (dut.r_ptr !== 2'd0 || dut.r_state !== 1'b0) begin
         failures++; $display("FAIL midreset_state got ptr=%0d state=%0d exp 0 0", dut.r_ptr, dut.r_state);
      end
      rst = 1'b0;
      clear_lanes();
   endtask

   task automatic test_one_lane();
      int k, last_acc;
      logic acc;
      b_out_ready = 1'b1;
      b_last = 1'b1;
      b_data = 16'h0;
      b_valid = 1'b1;
      k = 0; last_acc = -1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (b_out_valid) begin
            checks++;
            if (b_out_lane !== 1'b0 || b_out_data !== 16'(k - 1) || b_out_last !== 1'b1) begin
               failures++;
               $display("FAIL one_out got lane=%0d d=%h last=%b exp lane=0 d=%h last=1", b_out_lane, b_out_data, b_out_last, 16'(k - 1));
            end
         end
         acc = b_valid[0] && b_ready[0];
         if (acc) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != 2) begin failures++; $display("FAIL one_interval got=%0d exp=2", cyc - last_acc); end
            end
            last_acc = cyc;
         end
         @(posedge clk);
         #1;
         if (acc) begin k++; b_data = 16'(k); end
      end
      b_valid = 1'b0;
      checks++;
      if (k != 12) begin failures++; $display("FAIL one_count got=%0d exp=12", k); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_wrap();
      test_stall_reset();
      test_one_lane();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
